ber_checker: RTL and testbench

BER_CHECKER -- requirements
Module: ber_checker

---
 rtl/ber_checker.sv | 154 +++++++++++++++
 tb/tb_ber_checker.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ber_checker.sv
// PRBS7 (x^7+x^6+1) bit-error-rate checker: self-synchronises to the incoming
// stream, tracks lock with a windowed error budget and keeps saturating BER statistics.
module ber_checker #(
    parameter int unsigned LOCK_MATCH = 16,
    parameter int unsigned LOSS_ERRS  = 8,
    parameter int unsigned LOSS_WIN   = 64
) (
    input  logic        clk_signal,
    input  logic        rst_n,
    input  logic        signal,
    input  logic        bit_valid,
    input  logic        clear,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count,
    output logic [23:0] bit_count,
    output logic [1:0]  state
);

    localparam int unsigned MW = $clog2(LOCK_MATCH + 1);
    localparam int unsigned WW = $clog2(LOSS_WIN + 1);
    localparam int unsigned EW = $clog2(LOSS_ERRS + 1);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t          r_state,     w_state;
    logic [6:0]      r_lfsr,      w_lfsr;
    logic [2:0]      r_load,      w_load;
    logic [MW-1:0]   r_match,     w_match;
    logic [WW-1:0]   r_wbits,     w_wbits;
    logic [EW-1:0]   r_werrs,     w_werrs;
    logic [15:0]     r_err_count, w_err_count;
    logic [23:0]     r_bit_count, w_bit_count;
    logic            r_err_pulse, w_err_pulse;

    logic            w_pred;
    logic            w_miss;
    logic [WW-1:0]   w_wbits_inc;
    logic [EW-1:0]   w_werrs_inc;

    // State register: synchronous reset dominates everything
    always_ff @(posedge clk_signal) begin
        if (!rst_n) begin
            r_state     <= SEARCH;
            r_lfsr      <= '0;
            r_load      <= '0;
            r_match     <= '0;
            r_wbits     <= '0;
            r_werrs     <= '0;
            r_err_count <= '0;
            r_bit_count <= '0;
            r_err_pulse <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_lfsr      <= w_lfsr;
            r_load      <= w_load;
            r_match     <= w_match;
            r_wbits     <= w_wbits;
            r_werrs     <= w_werrs;
            r_err_count <= w_err_count;
            r_bit_count <= w_bit_count;
            r_err_pulse <= w_err_pulse;
        end
    end

    assign w_pred      = r_lfsr[6] ^ r_lfsr[5];
    assign w_miss      = signal ^ w_pred;
    assign w_wbits_inc = r_wbits + WW'(1);
    assign w_werrs_inc = r_werrs + EW'(w_miss);

    // Next-state and statistics update; nothing moves on invalid cycles
    always_comb begin
        w_state     = r_state;
        w_lfsr      = r_lfsr;
        w_load      = r_load;
        w_match     = r_match;
        w_wbits     = r_wbits;
        w_werrs     = r_werrs;
        w_err_count = r_err_count;
        w_bit_count = r_bit_count;
        w_err_pulse = 1'b0;

        if (bit_valid) begin
            unique case (r_state)
                SEARCH: begin
                    w_lfsr = {r_lfsr[5:0], signal};
                    if (r_load == 3'd6) begin
                        w_state = VERIFY;
                        w_load  = '0;
                        w_match = '0;
                    end else begin
                        w_load = r_load + 3'd1;
                    end
                end
                VERIFY: begin
                    w_lfsr = {r_lfsr[5:0], w_pred};
                    if (w_miss) begin
                        w_state = SEARCH;
                        w_load  = '0;
                    end else if (r_match == MW'(LOCK_MATCH - 1)) begin
                        w_state = LOCKED;
                        w_match = '0;
                        w_wbits = '0;
                        w_werrs = '0;
                    end else begin
                        w_match = r_match + MW'(1);
                    end
                end
                LOCKED: begin
                    w_lfsr = {r_lfsr[5:0], w_pred};
                    if (r_bit_count != '1) w_bit_count = r_bit_count + 24'd1;
                    if (w_miss) begin
                        w_err_pulse = 1'b1;
                        if (r_err_count != '1) w_err_count = r_err_count + 16'd1;
                    end
                    // Loss of lock wins over a window rollover on the same bit
                    if (w_werrs_inc == EW'(LOSS_ERRS)) begin
                        w_state = SEARCH;
                        w_load  = '0;
                        w_wbits = '0;
                        w_werrs = '0;
                    end else if (w_wbits_inc == WW'(LOSS_WIN)) begin
                        w_wbits = '0;
                        w_werrs = '0;
                    end else begin
                        w_wbits = w_wbits_inc;
                        w_werrs = w_werrs_inc;
                    end
                end
                default: begin
                    w_state = SEARCH;
                    w_load  = '0;
                end
            endcase
        end

        if (clear) begin
            w_err_count = '0;
            w_bit_count = '0;
            w_err_pulse = 1'b0;
        end
    end

    assign locked    = (r_state == LOCKED);
    assign state     = r_state;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;
    assign bit_count = r_bit_count;

endmodule

// File: tb/tb_ber_checker.sv
// Scoreboard bench for ber_checker: a sequence-level PRBS7 reference model predicts
// every cycle's outputs; directed checkpoints confirm lock timing and corner cases.
module tb_ber_checker;

    localparam int unsigned LOCK_MATCH = 16;
    localparam int unsigned LOSS_ERRS  = 8;
    localparam int unsigned LOSS_WIN   = 64;

    logic        clk_signal = 1'b0;
    logic        rst_n      = 1'b0;
    logic        signal     = 1'b0;
    logic        bit_valid  = 1'b0;
    logic        clear      = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [23:0] bit_count;
    logic [1:0]  state;

    ber_checker #(
        .LOCK_MATCH (LOCK_MATCH),
        .LOSS_ERRS  (LOSS_ERRS),
        .LOSS_WIN   (LOSS_WIN)
    ) dut (
        .clk_signal (clk_signal),
        .rst_n      (rst_n),
        .signal     (signal),
        .bit_valid  (bit_valid),
        .clear      (clear),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_count  (err_count),
        .bit_count  (bit_count),
        .state      (state)
    );

    always #5 clk_signal = ~clk_signal;

    typedef struct {
        logic [1:0]  st;
        logic        lk;
        logic        ep;
        logic [15:0] ec;
        logic [23:0] bc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model: phase 0/1/2 = hunting/confirming/locked
    int          m_phase, m_loaded, m_good, m_wbits, m_werrs;
    int unsigned m_errs, m_bits;
    bit          m_pulse;
    bit          hist[$];
    logic [6:0]  src = 7'h7F;

    function automatic bit src_next();
        bit b;
        b   = src[6] ^ src[5];
        src = {src[5:0], b};
        return b;
    endfunction

    task automatic model(input bit r, input bit v, input bit b, input bit c);
        bit p;
        if (!r) begin
            m_phase = 0; m_loaded = 0; m_good = 0; m_wbits = 0; m_werrs = 0;
            m_errs = 0; m_bits = 0; m_pulse = 0;
            hist.delete();
        end else begin
            m_pulse = 0;
            if (v) begin
                if (m_phase == 0) begin
                    hist.push_back(b);
                    if (hist.size() > 7) void'(hist.pop_front());
                    m_loaded++;
                    if (m_loaded == 7) begin
                        m_phase = 1; m_loaded = 0; m_good = 0;
                    end
                end else begin
                    // next PRBS7 bit = bit seven back XOR bit six back
                    p = hist[0] ^ hist[1];
                    void'(hist.pop_front());
                    hist.push_back(p);
                    if (m_phase == 1) begin
                        if (b == p) begin
                            m_good++;
                            if (m_good == LOCK_MATCH) begin
                                m_phase = 2; m_wbits = 0; m_werrs = 0;
                            end
                        end else begin
                            m_phase = 0; m_loaded = 0;
                        end
                    end else begin
                        if (m_bits < 32'h00FF_FFFF) m_bits++;
                        m_wbits++;
                        if (b != p) begin
                            if (m_errs < 32'h0000_FFFF) m_errs++;
                            m_werrs++;
                            m_pulse = 1;
                        end
                        if (m_werrs == LOSS_ERRS) begin
                            m_phase = 0; m_loaded = 0; m_wbits = 0; m_werrs = 0;
                        end else if (m_wbits == LOSS_WIN) begin
                            m_wbits = 0; m_werrs = 0;
                        end
                    end
                end
            end
            if (c) begin
                m_errs = 0; m_bits = 0; m_pulse = 0;
            end
        end
    endtask

    task automatic step(input bit r, input bit v, input bit inv, input bit c);
        bit b;
        @(negedge clk_signal);
        b         = v ? (src_next() ^ inv) : 1'($urandom_range(0, 1));
        rst_n     = r;
        bit_valid = v;
        signal    = b;
        clear     = c;
        model(r, v, b, c);
        sb.push_back('{st: 2'(m_phase), lk: (m_phase == 2), ep: m_pulse,
                       ec: 16'(m_errs), bc: 24'(m_bits)});
    endtask

    task automatic settle();
        @(posedge clk_signal);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Monitor: one scoreboard entry retires per clock edge
    initial begin
        forever begin
            @(posedge clk_signal);
            #1;
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                n_vec++;
                if ({state, locked, err_pulse, err_count, bit_count} !==
                    {e.st, e.lk, e.ep, e.ec, e.bc}) begin
                    n_bad++;
                    $display("FAIL scoreboard t=%0t: st/lk/ep/ec/bc got %0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d",
                             $time, state, locked, err_pulse, err_count, bit_count,
                             e.st, e.lk, e.ep, e.ec, e.bc);
                end
            end
        end
    end

    initial begin
        int nv;
        int rate;
        repeat (3) step(0, 1, 0, 0);
        chk("reset_state", state, 0);
        chk("reset_locked", locked, 0);

        // Clean stream: VERIFY after bit 7, LOCKED after bit 23
        for (int i = 1; i <= 30; i++) begin
            step(1, 1, 0, 0); settle();
            chk("lock_state", state, (i < 7) ? 0 : ((i < 23) ? 1 : 2));
            chk("lock_bits", bit_count, (i > 23) ? (i - 23) : 0);
            chk("lock_errs", err_count, 0);
        end

        // One inverted bit per 16 stays inside the window budget
        for (int k = 0; k < 128; k++) begin
            step(1, 1, (k % 16) == 15, 0);
            if ((k % 16) == 15) begin
                settle();
                chk("sparse_pulse", err_pulse, 1);
                chk("sparse_errs", err_count, (k + 1) / 16);
                chk("sparse_locked", locked, 1);
            end
        end

        // Burst of LOSS_ERRS errors drops lock on the last one
        step(0, 1, 0, 0);
        repeat (23) step(1, 1, 0, 0);
        settle(); chk("burst_prelock", locked, 1);
        for (int k = 1; k <= 8; k++) begin
            step(1, 1, 1, 0); settle();
            chk("burst_state", state, (k < 8) ? 2 : 0);
        end
        chk("burst_errs", err_count, 8);
        for (int k = 1; k <= 23; k++) begin
            step(1, 1, 0, 0); settle();
            chk("relock", locked, (k == 23));
        end
        chk("relock_errs", err_count, 8);

        // Error while verifying at match count 10
        step(0, 1, 0, 0);
        repeat (17) step(1, 1, 0, 0);
        step(1, 1, 1, 0); settle();
        chk("verify_err_state", state, 0);
        chk("verify_err_errs", err_count, 0);
        for (int k = 1; k <= 23; k++) begin
            step(1, 1, 0, 0); settle();
            chk("verify_relock", state, (k < 7) ? 0 : ((k < 23) ? 1 : 2));
        end

        // Alternating bit_valid: timing counts valid bits only
        step(0, 1, 0, 0);
        for (int i = 0; i < 50; i++) begin
            step(1, (i % 2) == 0, 0, 0); settle();
            nv = (i + 2) / 2;
            chk("gap_locked", locked, nv >= 23);
            chk("gap_bits", bit_count, (nv > 23) ? (nv - 23) : 0);
        end

        // Clear on an erroneous locked bit
        step(1, 1, 1, 1); settle();
        chk("clear_errs", err_count, 0);
        chk("clear_bits", bit_count, 0);
        chk("clear_pulse", err_pulse, 0);
        chk("clear_locked", locked, 1);

        // One-cycle reset mid-lock
        repeat (3) step(1, 1, 0, 0);
        step(0, 1, 1, 1); settle();
        chk("rst_state", state, 0);
        chk("rst_locked", locked, 0);
        chk("rst_bits", bit_count, 0);
        for (int k = 1; k <= 23; k++) begin
            step(1, 1, 0, 0); settle();
            chk("rst_relock", locked, (k == 23));
        end

        // Randomised traffic at several error densities
        for (int s = 0; s < 4; s++) begin
            rate = (s == 0) ? 200 : (s == 1) ? 40 : (s == 2) ? 8 : 3;
            for (int i = 0; i < 800; i++)
                step(($urandom % 1000) != 0, ($urandom % 4) != 0,
                     ($urandom % rate) == 0, ($urandom % 150) == 0);
        end

        repeat (3) @(posedge clk_signal);
        #2;
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
